// File: rtl/pong_round_controller_if.sv
// Signal bundle between the pong round controller and the VGA timing / game datapath side.
// master = controller, slave = timing block, buttons and datapath.
interface pong_round_controller_if;
    logic [9:0]  xpos;
    logic [9:0]  ypos;
    logic        btn_start;
    logic        btn_pause;
    logic        hit;
    logic        missed;
    logic        game_pause;
    logic        game_reset;
    logic [1:0]  lives;
    logic [15:0] score_bcd;
    logic [15:0] high_bcd;
    logic [2:0]  state;

    modport master (
        input  xpos, ypos, btn_start, btn_pause, hit, missed,
        output game_pause, game_reset, lives, score_bcd, high_bcd, state
    );

    modport slave (
        output xpos, ypos, btn_start, btn_pause, hit, missed,
        input  game_pause, game_reset, lives, score_bcd, high_bcd, state
    );
endinterface

// File: rtl/pong_round_controller.sv
// Pong round sequencing: serve delay, play, pause, miss display and game over,
// with BCD score, session high score and life tracking.
module pong_round_controller #(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 90
) (
    input  logic                    clk25,
    input  logic                    Reset,
    pong_round_controller_if.master bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        PLAY   = 3'd2,
        PAUSED = 3'd3,
        MISS   = 3'd4,
        OVER   = 3'd5
    } state_t;

    localparam logic [7:0] SERVE_CNT  = 8'(SERVE_FRAMES);
    localparam logic [7:0] MISS_CNT   = 8'(MISS_FRAMES);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);

    function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry && (r[i*4 +: 4] == 4'd9)) begin
                    r[i*4 +: 4] = 4'd0;
                end else if (carry) begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end else begin
                    carry = 1'b0;
                end
            end
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [3:0]  raw_s;
    logic [3:0]  sync1_r, sync2_r, sync3_r, ev_r;
    logic [1:0]  settle_r;
    logic        start_ev_s, pause_ev_s, hit_ev_s, miss_ev_s, frame_tick_s;
    state_t      state_r, state_nx;
    logic [7:0]  frame_cnt_r, cnt_nx;
    logic [1:0]  lives_r, lives_nx;
    logic [15:0] score_r, score_nx, high_r, high_nx;
    logic        game_pause_r, game_reset_r;

    assign raw_s        = {bus.missed, bus.hit, bus.btn_pause, bus.btn_start};
    assign start_ev_s   = ev_r[0];
    assign pause_ev_s   = ev_r[1];
    assign hit_ev_s     = ev_r[2];
    assign miss_ev_s    = ev_r[3];
    assign frame_tick_s = (bus.xpos == 10'd0) && (bus.ypos == 10'd480);

    // Synchronise inputs and detect rising edges; edges are only trusted once the
    // pipeline holds post-reset samples, so a button held through reset stays silent.
    always_ff @(posedge clk25) begin
        if (Reset) begin
            sync1_r  <= 4'b0000;
            sync2_r  <= 4'b0000;
            sync3_r  <= 4'b0000;
            ev_r     <= 4'b0000;
            settle_r <= 2'd0;
        end else begin
            sync1_r  <= raw_s;
            sync2_r  <= sync1_r;
            sync3_r  <= sync2_r;
            settle_r <= (settle_r == 2'd3) ? 2'd3 : settle_r + 2'd1;
            ev_r     <= (settle_r == 2'd3) ? (sync2_r & ~sync3_r) : 4'b0000;
        end
    end

    // Round sequencing: next state, frame counter, lives and score.
    always_comb begin
        state_nx = state_r;
        cnt_nx   = frame_cnt_r;
        lives_nx = lives_r;
        score_nx = score_r;
        high_nx  = high_r;
        case (state_r)
            IDLE: begin
                if (start_ev_s) begin
                    lives_nx = LIVES_INIT;
                    score_nx = 16'h0000;
                    cnt_nx   = SERVE_CNT;
                    state_nx = SERVE;
                end else begin
                    state_nx = IDLE;
                end
            end
            SERVE: begin
                if (frame_tick_s) begin
                    cnt_nx   = frame_cnt_r - 8'd1;
                    state_nx = (frame_cnt_r == 8'd1) ? PLAY : SERVE;
                end else begin
                    state_nx = SERVE;
                end
            end
            PLAY: begin
                if (hit_ev_s) begin
                    score_nx = bcd_inc_sat(score_r);
                end else begin
                    score_nx = score_r;
                end
                // A miss outranks a same-cycle pause; the final score feeds the high-score compare.
                if (miss_ev_s && (lives_r > 2'd1)) begin
                    lives_nx = lives_r - 2'd1;
                    cnt_nx   = MISS_CNT;
                    state_nx = MISS;
                end else if (miss_ev_s) begin
                    lives_nx = 2'd0;
                    high_nx  = (score_nx > high_r) ? score_nx : high_r;
                    state_nx = OVER;
                end else if (pause_ev_s) begin
                    state_nx = PAUSED;
                end else begin
                    state_nx = PLAY;
                end
            end
            PAUSED: begin
                if (pause_ev_s) begin
                    state_nx = PLAY;
                end else begin
                    state_nx = PAUSED;
                end
            end
            MISS: begin
                if (frame_tick_s && (frame_cnt_r == 8'd1)) begin
                    cnt_nx   = SERVE_CNT;
                    state_nx = SERVE;
                end else if (frame_tick_s) begin
                    cnt_nx   = frame_cnt_r - 8'd1;
                    state_nx = MISS;
                end else begin
                    state_nx = MISS;
                end
            end
            OVER: begin
                if (start_ev_s) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = OVER;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers; game_reset is held in IDLE and pulses on each SERVE entry.
    always_ff @(posedge clk25) begin
        if (Reset) begin
            state_r      <= IDLE;
            frame_cnt_r  <= 8'd0;
            lives_r      <= 2'd0;
            score_r      <= 16'h0000;
            high_r       <= 16'h0000;
            game_pause_r <= 1'b1;
            game_reset_r <= 1'b1;
        end else begin
            state_r      <= state_nx;
            frame_cnt_r  <= cnt_nx;
            lives_r      <= lives_nx;
            score_r      <= score_nx;
            high_r       <= high_nx;
            game_pause_r <= (state_nx != PLAY);
            game_reset_r <= (state_nx == IDLE) || ((state_nx == SERVE) && (state_r != SERVE));
        end
    end

    assign bus.state      = state_r;
    assign bus.lives      = lives_r;
    assign bus.score_bcd  = score_r;
    assign bus.high_bcd   = high_r;
    assign bus.game_pause = game_pause_r;
    assign bus.game_reset = game_reset_r;
endmodule
